// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache frame layout, FSM states and default geometry.
package cpu_types_pkg;

  localparam int WORD_W       = 32;
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_OFFW  = 2;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = WORD_W - ICACHE_OFFW - ICACHE_IDX_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  // Tag is stored right-aligned in a full word so any SETS/OFFW split fits.
  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] tag;
    logic [WORD_W-1:0] data;
  } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache. Hits return in the
// same cycle; a miss parks in FILL until memory drops iwait.
import cpu_types_pkg::*;

module icache #(
  parameter int SETS = ICACHE_SETS,
  parameter int OFFW = ICACHE_OFFW
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDXW   = $clog2(SETS);
  localparam int TSHIFT = OFFW + IDXW;

  icache_state_t state;
  icache_frame_t frames [SETS];
  logic [31:0]   miss_addr;

  logic [IDXW-1:0] live_idx;
  logic [IDXW-1:0] fill_idx;
  logic [31:0]     live_tag;
  logic [31:0]     fill_tag;
  icache_frame_t   live_frame;
  logic            hit;
  logic            miss;
  logic            fill_done;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign live_idx   = imemaddr[OFFW +: IDXW];
  assign live_tag   = imemaddr >> TSHIFT;
  assign fill_idx   = miss_addr[OFFW +: IDXW];
  assign fill_tag   = miss_addr >> TSHIFT;
  assign live_frame = frames[live_idx];

  // Lookup against the live PC; only meaningful while no fill is outstanding.
  always_comb begin
    hit       = (state == IDLE) && imemREN && live_frame.valid &&
                (live_frame.tag == live_tag);
    miss      = (state == IDLE) && imemREN && !hit;
    fill_done = (state == FILL) && !iwait;
  end

  // Outputs decode straight from state registers so reset drops iREN at once.
  always_comb begin
    ihit     = hit;
    imemload = hit ? live_frame.data : 32'd0;
    iREN     = (state == FILL);
    iaddr    = (state == FILL) ? miss_addr : 32'd0;
  end

  // Control FSM, latched miss address and saturating statistics.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      miss_addr  <= 32'd0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit)
        hit_count <= sat_inc(hit_count);
      case (state)
        IDLE: begin
          if (miss) begin
            miss_addr  <= imemaddr;
            miss_count <= sat_inc(miss_count);
            state      <= FILL;
          end
        end
        FILL: begin
          // Completes regardless of what the fetch stage is doing now.
          if (!iwait)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame storage: written only when memory returns the missed word.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++)
        frames[i] <= '0;
    end else if (fill_done) begin
      frames[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: iload};
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus randomized fetch traffic checked
// against an array-based cache model.
`timescale 1ns/1ps
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'd0;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'd0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Values observed mid-cycle, and what the model says they should be.
  logic        s_ihit, s_iren, e_ihit, e_iren;
  logic [31:0] s_load, s_iaddr, e_load, e_iaddr;

  // Reference model: 16 frames, word-addressed, tag = addr / 64.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_fill;
  logic [31:0] m_faddr;
  longint      m_hits, m_miss;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'sd4294967295) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_data[i] = 0;
    end
    m_fill = 0; m_faddr = 0; m_hits = 0; m_miss = 0;
  endtask

  task automatic model_step(input logic ren, input logic [31:0] a,
                            input logic w, input logic [31:0] ld);
    int i, j;
    i = int'((a / 32'd4) % 32'd16);
    if (!m_fill) begin
      e_iren = 0; e_iaddr = 0;
      if (ren && m_valid[i] && m_tag[i] == a / 32'd64) begin
        e_ihit = 1; e_load = m_data[i]; m_hits++;
      end else begin
        e_ihit = 0; e_load = 0;
        if (ren) begin m_miss++; m_fill = 1; m_faddr = a; end
      end
    end else begin
      e_ihit = 0; e_load = 0; e_iren = 1; e_iaddr = m_faddr;
      if (!w) begin
        j = int'((m_faddr / 32'd4) % 32'd16);
        m_valid[j] = 1; m_tag[j] = m_faddr / 32'd64; m_data[j] = ld; m_fill = 0;
      end
    end
  endtask

  // One clock: drive at posedge+1, sample at negedge, return at next posedge+1.
  task automatic cycle(input logic ren, input logic [31:0] a,
                       input logic w, input logic [31:0] ld);
    imemREN = ren; imemaddr = a; iwait = w; iload = ld;
    @(negedge CLK);
    s_ihit = ihit; s_load = imemload; s_iren = iREN; s_iaddr = iaddr;
    model_step(ren, a, w, ld);
    @(posedge CLK); #1;
  endtask

  // Hold the current fetch inputs, keep memory busy lat cycles, then answer.
  task automatic run_fill(input int lat);
    for (int k = 0; k < lat; k++) cycle(imemREN, imemaddr, 1'b1, 32'd0);
    cycle(imemREN, imemaddr, 1'b0, mem_word(m_faddr));
  endtask

  task automatic do_reset();
    nRST = 0; imemREN = 0; imemaddr = 0; iwait = 1; iload = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
  endtask

  task automatic test_reset();
    nRST = 0; imemREN = 1; imemaddr = 32'd0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if (ihit !== 1'b0) begin n_bad++; $display("FAIL reset_ihit: got %b want 0", ihit); end
    n_cmp++; if (imemload !== 32'd0) begin n_bad++; $display("FAIL reset_load: got %h want 0", imemload); end
    n_cmp++; if (iREN !== 1'b0) begin n_bad++; $display("FAIL reset_iren: got %b want 0", iREN); end
    n_cmp++; if (iaddr !== 32'd0) begin n_bad++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
    n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count);
    end
    nRST = 1;
  endtask

  task automatic test_first_miss();
    cycle(1'b1, 32'h0, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b0) begin n_bad++; $display("FAIL first_miss_c0: ihit got %b want 0", s_ihit); end
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b1, 32'h0, (k == 4) ? 1'b0 : 1'b1, (k == 4) ? 32'h2001_0005 : 32'd0);
      n_cmp++; if (s_ihit !== 1'b0 || s_iren !== 1'b1 || s_iaddr !== 32'h0) begin
        n_bad++; $display("FAIL first_miss_fill c%0d: ihit/iREN/iaddr got %b/%b/%h want 0/1/0", k, s_ihit, s_iren, s_iaddr);
      end
    end
    cycle(1'b1, 32'h0, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b1 || s_load !== 32'h2001_0005) begin
      n_bad++; $display("FAIL first_miss_hit: got %b/%h want 1/20010005", s_ihit, s_load);
    end
    n_cmp++; if (miss_count !== 32'd1) begin n_bad++; $display("FAIL first_miss_count: got %0d want 1", miss_count); end
  endtask

  task automatic test_repeat_hits();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h0, 1'b1, 32'd0);
      n_cmp++; if (s_ihit !== 1'b1 || s_iren !== 1'b0 || s_load !== 32'h2001_0005) begin
        n_bad++; $display("FAIL repeat_hit c%0d: ihit/iREN/load got %b/%b/%h want 1/0/20010005", k, s_ihit, s_iren, s_load);
      end
    end
    cycle(1'b0, 32'h0, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b0 || s_load !== 32'd0) begin
      n_bad++; $display("FAIL idle_noreq: ihit/load got %b/%h want 0/0", s_ihit, s_load);
    end
    n_cmp++; if (hit_count !== 32'd4) begin n_bad++; $display("FAIL repeat_hit_count: got %0d want 4", hit_count); end
  endtask

  task automatic test_conflict();
    cycle(1'b1, 32'h4, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b0) begin n_bad++; $display("FAIL conflict_first: ihit got %b want 0", s_ihit); end
    run_fill(2);
    cycle(1'b1, 32'h44, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b0) begin n_bad++; $display("FAIL conflict_newtag: ihit got %b want 0", s_ihit); end
    cycle(1'b1, 32'h44, 1'b1, 32'd0);
    n_cmp++; if (s_iren !== 1'b1 || s_iaddr !== 32'h44) begin
      n_bad++; $display("FAIL conflict_iaddr: iREN/iaddr got %b/%h want 1/00000044", s_iren, s_iaddr);
    end
    run_fill(1);
    cycle(1'b1, 32'h4, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b0) begin n_bad++; $display("FAIL conflict_evicted: ihit got %b want 0", s_ihit); end
    run_fill(0);
  endtask

  task automatic test_redirect();
    cycle(1'b1, 32'h8, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b0) begin n_bad++; $display("FAIL redirect_miss: ihit got %b want 0", s_ihit); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h100, (k == 2) ? 1'b0 : 1'b1, (k == 2) ? mem_word(32'h8) : 32'd0);
      n_cmp++; if (s_iren !== 1'b1 || s_iaddr !== 32'h8 || s_ihit !== 1'b0) begin
        n_bad++; $display("FAIL redirect_hold c%0d: iREN/iaddr/ihit got %b/%h/%b want 1/00000008/0", k, s_iren, s_iaddr, s_ihit);
      end
    end
    cycle(1'b1, 32'h100, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b0 || s_iren !== 1'b0) begin
      n_bad++; $display("FAIL redirect_newmiss: ihit/iREN got %b/%b want 0/0", s_ihit, s_iren);
    end
    cycle(1'b1, 32'h100, 1'b1, 32'd0);
    n_cmp++; if (s_iaddr !== 32'h100) begin n_bad++; $display("FAIL redirect_iaddr: got %h want 00000100", s_iaddr); end
    run_fill(0);
    cycle(1'b1, 32'h8, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b1 || s_load !== mem_word(32'h8)) begin
      n_bad++; $display("FAIL redirect_kept: got %b/%h want 1/%h", s_ihit, s_load, mem_word(32'h8));
    end
  endtask

  task automatic test_reset_mid_fill();
    cycle(1'b1, 32'hC, 1'b1, 32'd0);
    cycle(1'b1, 32'hC, 1'b1, 32'd0);
    n_cmp++; if (iREN !== 1'b1) begin n_bad++; $display("FAIL midfill_pre: iREN got %b want 1", iREN); end
    #1 nRST = 0;
    #1;
    n_cmp++; if (iREN !== 1'b0 || iaddr !== 32'd0) begin
      n_bad++; $display("FAIL midfill_async: iREN/iaddr got %b/%h want 0/0", iREN, iaddr);
    end
    model_reset();
    @(posedge CLK); #1 nRST = 1;
    cycle(1'b1, 32'hC, 1'b1, 32'd0);
    n_cmp++; if (s_ihit !== 1'b0) begin n_bad++; $display("FAIL midfill_reread: ihit got %b want 0", s_ihit); end
    n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd1) begin
      n_bad++; $display("FAIL midfill_counts: got %0d/%0d want 0/1", hit_count, miss_count);
    end
    run_fill(1);
  endtask

  task automatic test_sequential();
    int misses, hits;
    do_reset();
    misses = 0; hits = 0;
    for (int a = 0; a < 64; a += 4) begin
      cycle(1'b1, 32'(a), 1'b1, 32'd0);
      if (s_ihit === 1'b0) misses++;
      run_fill(int'($urandom_range(0, 2)));
    end
    for (int a = 0; a < 64; a += 4) begin
      cycle(1'b1, 32'(a), 1'b1, 32'd0);
      if (s_ihit === 1'b1 && s_load === mem_word(32'(a))) hits++;
    end
    n_cmp++; if (misses != 16 || hits != 16) begin
      n_bad++; $display("FAIL seq_pattern: misses/hits got %0d/%0d want 16/16", misses, hits);
    end
    n_cmp++; if (miss_count !== 32'd16 || hit_count !== 32'd16) begin
      n_bad++; $display("FAIL seq_counters: got %0d/%0d want 16/16", miss_count, hit_count);
    end
  endtask

  task automatic test_random();
    logic        ren, w;
    logic [31:0] a;
    int          errs;
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      ren = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        a = $urandom;
      else
        a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      w = m_fill ? ($urandom_range(0, 2) != 0) : 1'($urandom_range(0, 1));
      cycle(ren, a, w, $urandom);
      n_cmp++;
      if (s_ihit !== e_ihit || s_load !== e_load || s_iren !== e_iren || s_iaddr !== e_iaddr) begin
        n_bad++; errs++;
        if (errs < 10)
          $display("FAIL random c%0d: ihit/load/iREN/iaddr got %b/%h/%b/%h want %b/%h/%b/%h",
                   k, s_ihit, s_load, s_iren, s_iaddr, e_ihit, e_load, e_iren, e_iaddr);
      end
    end
    n_cmp++; if (hit_count !== sat32(m_hits) || miss_count !== sat32(m_miss)) begin
      n_bad++; $display("FAIL random_counters: got %0d/%0d want %0d/%0d", hit_count, miss_count, m_hits, m_miss);
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_repeat_hits();
    test_conflict();
    test_redirect();
    test_reset_mid_fill();
    test_sequential();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
